// File: rtl/byte_gather8_pkg.sv
// byte_gather8_pkg: shared defaults and types for the byte gather stage.
//   DEF_WIDTH / DEF_LANES : default byte width and bundle lane count
//   state_t               : control FSM encoding (FILL, FULL)
//   lane_t                : one lane at the default width
package byte_gather8_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LANES = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef logic [DEF_WIDTH-1:0] lane_t;

endpackage

// File: rtl/gather_lane_reg.sv
// gather_lane_reg: one bundle lane register.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   we_i, d_i    : load d_i (takes priority over clear)
//   clr_i        : clear lane to zero
//   q_o          : lane contents
module gather_lane_reg
  import byte_gather8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end else if (clr_i) begin
      q_q <= '0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/byte_gather8.sv
// byte_gather8: deserialises a valid/ready byte stream into an 8-lane bundle
// for the downstream XOR fold. I_last closes a partial bundle; unwritten
// lanes stay zero. A full bundle can drain while the first byte of the next
// one is accepted in the same cycle.
//   CLK, ASYNCRESET         : clock, asynchronous active-high reset
//   I, I_valid, I_last      : input byte stream (I_last closes the bundle)
//   I_ready                 : byte accepted this cycle when I_valid
//   O0..O7, O_count         : bundle lanes (O0 first byte), real lane count
//   O_valid, O_ready        : bundle handshake
//   P                       : running XOR of the bundle, only when
//                             BYTE_GATHER8_PARITY_EN is defined
module byte_gather8
  import byte_gather8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned CW    = $clog2(LANES) + 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  input  logic             I_last,
  output logic             I_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [CW-1:0]    O_count,
  output logic             O_valid,
  input  logic             O_ready
`ifdef BYTE_GATHER8_PARITY_EN
  ,
  output logic [WIDTH-1:0] P
`endif
);

  localparam int unsigned IW = $clog2(LANES);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [LANES-1:0] lane_we;
  logic             lane_clr;
  logic             accept;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [WIDTH-1:0] vis [8];

  assign O_valid = (state_q == FULL);
  // Only combinational path: a held bundle frees space exactly when it drains.
  assign I_ready = (state_q == FILL) | O_ready;
  assign accept  = I_valid & I_ready;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    lane_we  = '0;
    lane_clr = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          lane_we[idx_q] = 1'b1;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IW'(LANES - 1) || I_last) begin
            count_d = CW'(idx_q) + CW'(1);
            state_d = FULL;
            idx_d   = '0;
          end
        end
      end
      FULL: begin
        if (O_ready) begin
          // Drain: clear every lane; a simultaneous byte reloads lane 0 and
          // starts the next bundle (or is a whole bundle if it carries I_last).
          lane_clr = 1'b1;
          state_d  = FILL;
          if (accept) begin
            lane_we[0] = 1'b1;
            idx_d      = IW'(1);
            if (I_last) begin
              count_d = CW'(1);
              state_d = FULL;
              idx_d   = '0;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gather_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk_i (CLK),
      .rst_i (ASYNCRESET),
      .we_i  (lane_we[k]),
      .clr_i (lane_clr),
      .d_i   (I),
      .q_o   (lane_q[k])
    );
  end

  for (genvar k = 0; k < 8; k++) begin : g_vis
    if (k < LANES) begin : g_real
      assign vis[k] = lane_q[k];
    end else begin : g_pad
      assign vis[k] = '0;
    end
  end

  assign O0      = vis[0];
  assign O1      = vis[1];
  assign O2      = vis[2];
  assign O3      = vis[3];
  assign O4      = vis[4];
  assign O5      = vis[5];
  assign O6      = vis[6];
  assign O7      = vis[7];
  assign O_count = count_q;

`ifdef BYTE_GATHER8_PARITY_EN
  logic [WIDTH-1:0] par_q, par_d;

  // Mirrors the lane updates so P always equals the XOR of the lanes.
  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = (state_q == FULL) ? I : (par_q ^ I);
    end else if (O_valid && O_ready) begin
      par_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign P = par_q;
`endif

endmodule

// File: tb/tb_byte_gather8.sv
// tb_byte_gather8: scoreboard bench for byte_gather8. Stimulus pushes the
// expected bundle; a negedge monitor checks every presented bundle against
// the queue head and pops it when consumed. Handshake rules and latency are
// checked alongside.
module tb_byte_gather8;
  import byte_gather8_pkg::*;

  typedef struct packed {
    logic [63:0] lanes;
    logic [3:0]  cnt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        ASYNCRESET = 1'b0;
  lane_t       I = '0;
  logic        I_valid = 1'b0;
  logic        I_last = 1'b0;
  logic        I_ready;
  lane_t       O0, O1, O2, O3, O4, O5, O6, O7;
  logic [3:0]  O_count;
  logic        O_valid;
  logic        O_ready = 1'b1;
`ifdef BYTE_GATHER8_PARITY_EN
  lane_t       P;
`endif

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   stalls = 0;

  lane_t st [24] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h5A, 8'hC3, 8'h96, 8'h69,
                     8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1,
                     8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  byte_gather8 dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .I          (I),
    .I_valid    (I_valid),
    .I_last     (I_last),
    .I_ready    (I_ready),
    .O0         (O0),
    .O1         (O1),
    .O2         (O2),
    .O3         (O3),
    .O4         (O4),
    .O5         (O5),
    .O6         (O6),
    .O7         (O7),
    .O_count    (O_count),
    .O_valid    (O_valid),
    .O_ready    (O_ready)
`ifdef BYTE_GATHER8_PARITY_EN
    ,
    .P          (P)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic push_exp(input logic [63:0] l, input logic [3:0] c);
    exp_t e;
    e.lanes = l;
    e.cnt   = c;
    q.push_back(e);
  endtask

  // Present one byte, wait (bounded) for the handshake, release after the edge.
  task automatic send(input lane_t b, input bit last, input bit closes);
    int waited = 0;
    I       = b;
    I_last  = last;
    I_valid = 1'b1;
    @(negedge CLK);
    while (!I_ready && waited < 64) begin
      waited++;
      @(negedge CLK);
    end
    if (!I_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: byte %h never accepted, I_ready=%b required 1", b, I_ready);
    end
    stalls += waited;
    @(posedge CLK);
    #1;
    I_valid = 1'b0;
    I_last  = 1'b0;
    if (closes) begin
      checks++;
      if (O_valid !== 1'b1) begin
        fails++;
        $display("FAIL latency: O_valid=%b one cycle after closing byte %h, required 1", O_valid, b);
      end
    end
  endtask

  task automatic check_zero(input string name);
    logic [68:0] got;
    got = {O_valid, O_count, O7, O6, O5, O4, O3, O2, O1, O0};
    checks++;
    if (got !== '0) begin
      fails++;
      $display("FAIL %s: outputs {valid,count,lanes}=%h required 0", name, got);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (!ASYNCRESET) begin
      logic        exp_rdy;
      logic [63:0] got;
      exp_t        e;
      lane_t       par;
      exp_rdy = O_valid ? O_ready : 1'b1;
      checks++;
      if (I_ready !== exp_rdy) begin
        fails++;
        $display("FAIL i_ready: I_ready=%b required %b (O_valid=%b O_ready=%b)", I_ready, exp_rdy, O_valid, O_ready);
      end
      if (O_valid) begin
        got = {O7, O6, O5, O4, O3, O2, O1, O0};
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_bundle: lanes=%h count=%0d with empty scoreboard", got, O_count);
        end else begin
          e = q[0];
          if (got !== e.lanes || O_count !== e.cnt) begin
            fails++;
            $display("FAIL bundle: lanes=%h count=%0d, required lanes=%h count=%0d", got, O_count, e.lanes, e.cnt);
          end
`ifdef BYTE_GATHER8_PARITY_EN
          par = '0;
          for (int k = 0; k < 8; k++) par = par ^ e.lanes[8*k +: 8];
          checks++;
          if (P !== par) begin
            fails++;
            $display("FAIL parity: P=%h required %h", P, par);
          end
`else
          par = '0;
`endif
          if (O_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] l;
    int          s0;

    // Reset state
    #1 ASYNCRESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset_state");
    ASYNCRESET = 1'b0;

    // Full bundle 01..08
    push_exp(64'h0807_0605_0403_0201, 4'd8);
    for (int i = 1; i <= 8; i++) send(lane_t'(i), 1'b0, i == 8);

    // Partial bundle AA 55 FF
    push_exp(64'h0000_0000_00FF_55AA, 4'd3);
    send(8'hAA, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b1);

    // Backpressure: bundle held 5 cycles while 0x11 waits
    @(posedge CLK); #1;
    O_ready = 1'b0;
    push_exp(64'h2827_2625_2423_2221, 4'd8);
    for (int i = 1; i <= 8; i++) send(lane_t'(8'h20 + i), 1'b0, i == 8);
    I       = 8'h11;
    I_valid = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    O_ready = 1'b1;
    push_exp(64'h1817_1615_1413_1211, 4'd8);
    for (int i = 1; i <= 8; i++) send(lane_t'(8'h10 + i), 1'b0, i == 8);

    // Streaming 24 bytes
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 8; k++) l[8*k +: 8] = st[8*g + k];
      push_exp(l, 4'd8);
    end
    s0 = stalls;
    for (int i = 0; i < 24; i++) send(st[i], 1'b0, (i % 8) == 7);
    checks++;
    if (stalls != s0) begin
      fails++;
      $display("FAIL stream_stall: %0d stall cycles, required 0", stalls - s0);
    end

    // Back-to-back single-lane bundles
    push_exp(64'h0000_0000_0000_0031, 4'd1);
    push_exp(64'h0000_0000_0000_0032, 4'd1);
    push_exp(64'h0000_0000_0000_0033, 4'd1);
    push_exp(64'h0000_0000_0000_0034, 4'd1);
    for (int i = 1; i <= 4; i++) send(lane_t'(8'h30 + i), 1'b1, 1'b1);

    // I_last on the eighth byte
    push_exp(64'h5857_5655_5453_5251, 4'd8);
    for (int i = 1; i <= 8; i++) send(lane_t'(8'h50 + i), i == 8, i == 8);

    // Reset mid-fill discards the partial bundle
    for (int i = 1; i <= 4; i++) send(lane_t'(8'hE0 + i), 1'b0, 1'b0);
    #2 ASYNCRESET = 1'b1;
    #1;
    check_zero("reset_midfill");
    ASYNCRESET = 1'b0;
    push_exp(64'h4847_4645_4443_4241, 4'd8);
    for (int i = 1; i <= 8; i++) send(lane_t'(8'h40 + i), 1'b0, i == 8);

    // Drain scoreboard
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d bundles never delivered, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
